// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared CDB types and constants for the CDB arbiter slice
// Contents: CDB_TAG_W/CDB_DATA_W widths, cdb_t bus entry, cdb_state_e output register state
package cdb_arbiter_pkg;
    localparam int CDB_TAG_W = 4;
    localparam int CDB_DATA_W = 32;
    typedef struct packed {
        logic                  valid;
        logic [CDB_TAG_W-1:0]  tag;
        logic [CDB_DATA_W-1:0] data;
    } cdb_t;
    typedef enum logic {EMPTY, FULL} cdb_state_e;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: round-robin pick of the first set request at or after ptr, wrapping
// Ports: req (request vector), ptr (search start), grant (one-hot winner),
//        idx (encoded winner), any (some request set)
module rr_picker #(
    parameter int NUM_REQ = 17,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      idx,
    output logic               any
);
    function automatic logic [IW-1:0] wrap(input logic [IW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        return IW'(s >= NUM_REQ ? s - NUM_REQ : s);
    endfunction
    // Scan from the farthest offset back to ptr so the nearest request is written last.
    always_comb begin
        idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (req[wrap(ptr, k)]) idx = wrap(ptr, k);
        any = |req;
        grant = any ? NUM_REQ'(1) << idx : '0;
    end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter registering one completed result per cycle onto the CDB
// Ports: clk, rst (sync, active-high), flush (squash), req_valid/req_tag/req_data/req_is_br
//        per requester, req_grant (one-hot, combinational), cdb_valid/cdb_tag/cdb_data/cdb_src
//        (registered CDB entry), rob_ready (ROB consumes the entry)
// Option: CDB_BR_PRIORITY_EN gives branch results precedence over other results.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 17,
    parameter int TAG_W = 4,
    parameter int DATA_W = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*TAG_W-1:0]    req_tag,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_is_br,
    output logic [NUM_REQ-1:0]          req_grant,
    output logic                        cdb_valid,
    output logic [TAG_W-1:0]            cdb_tag,
    output logic [DATA_W-1:0]           cdb_data,
    output logic [$clog2(NUM_REQ)-1:0]  cdb_src,
    input  logic                        rob_ready
);
    localparam int IW = $clog2(NUM_REQ);
    cdb_state_e state, state_d;
    logic [IW-1:0] rr_ptr;
    logic [NUM_REQ-1:0] pick_grant;
    logic [IW-1:0] pick_idx;
    logic pick_any, can_load, grant_en, load;
    logic [TAG_W-1:0] win_tag;
    logic [DATA_W-1:0] win_data;
`ifdef CDB_BR_PRIORITY_EN
    logic [NUM_REQ-1:0] br_req, br_grant, all_grant;
    logic [IW-1:0] br_idx, all_idx;
    logic br_any;
    assign br_req = req_valid & req_is_br;
    rr_picker #(.NUM_REQ(NUM_REQ)) u_br (.req(br_req), .ptr(rr_ptr), .grant(br_grant), .idx(br_idx), .any(br_any));
    rr_picker #(.NUM_REQ(NUM_REQ)) u_all (.req(req_valid), .ptr(rr_ptr), .grant(all_grant), .idx(all_idx), .any(pick_any));
    assign pick_grant = br_any ? br_grant : all_grant;
    assign pick_idx = br_any ? br_idx : all_idx;
`else
    logic unused_is_br;
    assign unused_is_br = ^req_is_br;
    rr_picker #(.NUM_REQ(NUM_REQ)) u_all (.req(req_valid), .ptr(rr_ptr), .grant(pick_grant), .idx(pick_idx), .any(pick_any));
`endif
    // The register may take a new entry when empty or when the ROB drains it this cycle.
    assign can_load = (state == EMPTY) | rob_ready;
    assign grant_en = can_load & ~flush & ~rst;
    assign load = grant_en & pick_any;
    assign req_grant = grant_en ? pick_grant : '0;
    assign cdb_valid = state == FULL;
    always_comb begin
        win_tag = '0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (pick_grant[i]) begin
                win_tag = req_tag[i*TAG_W +: TAG_W];
                win_data = req_data[i*DATA_W +: DATA_W];
            end
    end
    always_comb begin
        state_d = state;
        if (flush) state_d = EMPTY;
        else if (can_load) state_d = pick_any ? FULL : EMPTY;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            rr_ptr <= '0;
            cdb_tag <= '0;
            cdb_data <= '0;
            cdb_src <= '0;
        end else begin
            state <= state_d;
            if (load) begin
                cdb_tag <= win_tag;
                cdb_data <= win_data;
                cdb_src <= pick_idx;
                rr_ptr <= (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
            end
        end
    end
endmodule
